// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet builder.
package pkt_pkg;

  // Merge-op selectors for data_sel
  localparam logic [3:0] OP0 = 4'd0;  // 1 byte per word, rdata[7:0]
  localparam logic [3:0] OP1 = 4'd1;  // 2 bytes per word, rdata[15:0]
  localparam logic [3:0] OP2 = 4'd2;  // 4 bytes per word

  localparam logic [7:0] CRC_POLY_DEF = 8'h07;

  // 2 header bytes + up to 16 payload bytes + 1 CRC byte, rounded to whole words
  localparam int MAX_FRAME = 20;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_CRC     = 3'd3,
    S_WR_ADDR = 3'd4,
    S_WR_DATA = 3'd5,
    S_WR_RESP = 3'd6,
    S_BAD     = 3'd7
  } pkt_state_e;

  // One CRC-8 step over a byte: MSB first, no reflection, no final XOR
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_unit.sv
// Byte-serial CRC-8 accumulator: clear, then one byte per enabled cycle.
module crc8_unit
  import pkt_pkg::*;
#(
  parameter logic [7:0] POLY = CRC_POLY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] crc_next
);

  logic [7:0] crc_q, crc_d;

  assign crc_next = crc8_step(crc_q, din, POLY);

  // Next accumulator value: clear wins over enable
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = crc_next;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/pkt_builder.sv
// Packet builder: burst-read a payload, frame it with a 2-byte header and a
// CRC-8 trailer, burst-write the frame.
//
// Handshakes: every AXI channel transfers on a cycle where valid && ready are
// both high at the rising clock edge; a source holds valid and its payload
// stable until that cycle, and valid never depends on ready.
module pkt_builder
  import pkt_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter logic [7:0] HDR_MAGIC = 8'hA5,
  parameter logic [7:0] CRC_POLY  = CRC_POLY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] out_addr,
  input  logic [3:0]        byte_cnt,
  input  logic [3:0]        data_sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  output logic              wlast,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [2:0]        dbg_state
);

  pkt_state_e        state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [7:0]        buf_q [MAX_FRAME];
  logic [7:0]        buf_d [MAX_FRAME];
  logic [4:0]        rd_idx_q, rd_idx_d;    // payload bytes consumed so far
  logic [4:0]        beat_q, beat_d;        // read beats seen (saturating)
  logic [4:0]        crc_idx_q, crc_idx_d;  // frame byte fed to the CRC
  logic [2:0]        wr_idx_q, wr_idx_d;    // output word index
  logic              rd_err_q, rd_err_d;    // sticky read-burst error

  logic       crc_clr, crc_en;
  logic [7:0] crc_din, crc_next;

  logic [1:0] bpw_sh;
  logic [4:0] bpw, cnt_ext, nrd, frame_len, nwr, wr_base;
  logic       wr_last;

  crc8_unit #(.POLY(CRC_POLY)) u_crc (
    .clk      (clk),
    .reset    (reset),
    .clr      (crc_clr),
    .en       (crc_en),
    .din      (crc_din),
    .crc_next (crc_next)
  );

  // Burst geometry derived from the latched request
  always_comb begin
    bpw_sh = 2'd0;
    if (sel_q == OP1) bpw_sh = 2'd1;
    if (sel_q == OP2) bpw_sh = 2'd2;
    bpw       = 5'd1 << bpw_sh;
    cnt_ext   = {1'b0, cnt_q};
    nrd       = (cnt_ext + bpw) >> bpw_sh;  // ceil((byte_cnt+1)/bpw)
    frame_len = cnt_ext + 5'd4;
    nwr       = (frame_len + 5'd3) >> 2;
    wr_base   = {wr_idx_q, 2'b00};
    wr_last   = ({2'b00, wr_idx_q} == (nwr - 5'd1));
  end

  // Address/data channel payloads, zero outside the state that drives them
  always_comb begin
    araddr = '0;
    arlen  = 8'h00;
    awaddr = '0;
    awlen  = 8'h00;
    wdata  = 32'h0;
    wstrb  = 4'h0;
    wlast  = 1'b0;
    if (state_q == S_RD_ADDR) begin
      araddr = in_addr_q;
      arlen  = {3'b000, nrd - 5'd1};
    end
    if (state_q == S_WR_ADDR) begin
      awaddr = out_addr_q;
      awlen  = {3'b000, nwr - 5'd1};
    end
    if (state_q == S_WR_DATA) begin
      wdata = {buf_q[wr_base + 5'd3], buf_q[wr_base + 5'd2],
               buf_q[wr_base + 5'd1], buf_q[wr_base]};
      wlast = wr_last;
      wstrb = 4'hF;
      if (wr_last) begin
        case (frame_len[1:0])
          2'd1:    wstrb = 4'h1;
          2'd2:    wstrb = 4'h3;
          2'd3:    wstrb = 4'h7;
          default: wstrb = 4'hF;
        endcase
      end
    end
  end

  // FSM next state, handshake outputs and buffer updates
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    in_addr_d  = in_addr_q;
    out_addr_d = out_addr_q;
    rd_idx_d   = rd_idx_q;
    beat_d     = beat_q;
    crc_idx_d  = crc_idx_q;
    wr_idx_d   = wr_idx_q;
    rd_err_d   = rd_err_q;
    for (int i = 0; i < MAX_FRAME; i++) buf_d[i] = buf_q[i];
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_din = 8'h00;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d      = data_sel;
          cnt_d      = byte_cnt;
          in_addr_d  = in_addr;
          out_addr_d = out_addr;
          rd_idx_d   = 5'd0;
          beat_d     = 5'd0;
          crc_idx_d  = 5'd0;
          wr_idx_d   = 3'd0;
          rd_err_d   = 1'b0;
          crc_clr    = 1'b1;
          for (int i = 0; i < MAX_FRAME; i++) buf_d[i] = 8'h00;
          buf_d[0] = {data_sel, byte_cnt};
          buf_d[1] = HDR_MAGIC;
          state_d  = (data_sel > OP2) ? S_BAD : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          // Bytes past byte_cnt are dropped; payload byte k lands at frame k+2
          for (int i = 0; i < 4; i++) begin
            if ((5'(i) < bpw) && ((rd_idx_q + 5'(i)) <= cnt_ext)) begin
              buf_d[rd_idx_q + 5'(i) + 5'd2] = rdata[8*i +: 8];
            end
          end
          if (rd_idx_q <= cnt_ext) rd_idx_d = rd_idx_q + bpw;
          // Extra beat past the expected count, or rlast on the wrong beat
          if ((beat_q >= nrd) || (rlast && (beat_q != (nrd - 5'd1)))) begin
            rd_err_d = 1'b1;
          end
          if (beat_q != 5'h1F) beat_d = beat_q + 5'd1;
          if (rlast) state_d = S_CRC;
        end
      end
      S_CRC: begin
        crc_en  = 1'b1;
        crc_din = buf_q[crc_idx_q];
        if (crc_idx_q == (frame_len - 5'd2)) begin
          buf_d[frame_len - 5'd1] = crc_next;
          state_d = S_WR_ADDR;
        end else begin
          crc_idx_d = crc_idx_q + 5'd1;
        end
      end
      S_WR_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        wvalid = 1'b1;
        if (wready) begin
          if (wr_last) state_d = S_WR_RESP;
          else         wr_idx_d = wr_idx_q + 3'd1;
        end
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          done    = 1'b1;
          err     = rd_err_q | (bresp != 2'b00);
          state_d = S_IDLE;
        end
      end
      S_BAD: begin
        // Unsupported merge op: report without touching the bus
        done    = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  // State, request and buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= 4'd0;
      cnt_q      <= 4'd0;
      in_addr_q  <= '0;
      out_addr_q <= '0;
      rd_idx_q   <= 5'd0;
      beat_q     <= 5'd0;
      crc_idx_q  <= 5'd0;
      wr_idx_q   <= 3'd0;
      rd_err_q   <= 1'b0;
      for (int i = 0; i < MAX_FRAME; i++) buf_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      in_addr_q  <= in_addr_d;
      out_addr_q <= out_addr_d;
      rd_idx_q   <= rd_idx_d;
      beat_q     <= beat_d;
      crc_idx_q  <= crc_idx_d;
      wr_idx_q   <= wr_idx_d;
      rd_err_q   <= rd_err_d;
      for (int i = 0; i < MAX_FRAME; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_pkt_builder.sv
// Bench for pkt_builder: table of packets played through a scripted AXI
// slave, expected output words queued by a frame model, plus hand sequences
// for the bad merge op and a reset in the middle of the write burst.
module tb_pkt_builder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in_addr, out_addr;
  logic [3:0]  byte_cnt, data_sel;
  logic        busy, done, err;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rlast, rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wlast, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  exp_strb_q[$];

  typedef struct {
    logic [3:0]        sel;
    logic [3:0]        cnt;
    int                nbeats;
    logic [15:0][31:0] beats;
    logic [7:0]        arlen;
    logic [7:0]        awlen;
    logic [1:0]        bresp;
    logic              exp_err;
    int                stall;
    logic              chk0;
    logic [31:0]       word0;
  } vec_t;

  vec_t vecs[7];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pkt_builder #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_addr(in_addr), .out_addr(out_addr),
    .byte_cnt(byte_cnt), .data_sel(data_sel),
    .busy(busy), .done(done), .err(err),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required $finish before it");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Frame model: header, payload extracted from the beats, CRC; pushes words
  task automatic build_expected(input vec_t v);
    logic [7:0] fr [20];
    logic [7:0] c;
    int bpw, k, flen, nw, rem;
    for (int i = 0; i < 20; i++) fr[i] = 8'h00;
    bpw   = (v.sel == 4'd0) ? 1 : (v.sel == 4'd1) ? 2 : 4;
    fr[0] = {v.sel, v.cnt};
    fr[1] = 8'hA5;
    for (int b = 0; b < v.nbeats; b++) begin
      for (int i = 0; i < bpw; i++) begin
        k = b * bpw + i;
        if (k <= int'(v.cnt)) fr[k + 2] = v.beats[b][8*i +: 8];
      end
    end
    flen = int'(v.cnt) + 4;
    c = 8'h00;
    for (int i = 0; i < flen - 1; i++) c = ref_crc_byte(c, fr[i]);
    fr[flen - 1] = c;
    nw  = (flen + 3) / 4;
    rem = flen % 4;
    for (int j = 0; j < nw; j++) begin
      exp_q.push_back({fr[4*j+3], fr[4*j+2], fr[4*j+1], fr[4*j]});
      if (j == nw - 1 && rem != 0) exp_strb_q.push_back(4'((1 << rem) - 1));
      else                         exp_strb_q.push_back(4'hF);
    end
  endtask

  task automatic clear_inputs();
    start = 0; arready = 0; rvalid = 0; rlast = 0; rdata = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
  endtask

  task automatic recover();
    clear_inputs();
    reset = 1; cyc(); reset = 0;
    exp_q.delete(); exp_strb_q.delete();
    #1;
  endtask

  // ---------------- driver: one packet through the scripted slave ----------------
  task automatic run_vec(input vec_t v, input int abort_at);
    logic [31:0] ia, oa, ew, m;
    logic [3:0]  es;
    int n, t, nw;
    ia = $urandom; oa = $urandom;
    build_expected(v);
    nw = exp_q.size();
    cyc();
    in_addr = ia; out_addr = oa; byte_cnt = v.cnt; data_sel = v.sel; start = 1;
    cyc();
    // Scramble request inputs: the packet must use the latched copies
    start = 0; in_addr = $urandom; out_addr = $urandom;
    byte_cnt = 4'($urandom); data_sel = 4'($urandom);
    #1;
    chk("busy_after_start", 32'(busy), 32'd1);
    t = 0;
    while (!arvalid && t < 20) begin cyc(); #1; t++; end
    if (!arvalid) begin chk("arvalid_wait", 32'(arvalid), 32'd1); recover(); return; end
    n = $urandom_range(0, v.stall);
    repeat (n) begin chk("ar_hold", 32'(arvalid), 32'd1); cyc(); #1; end
    chk("araddr", araddr, ia);
    chk("arlen", 32'(arlen), 32'(v.arlen));
    arready = 1; cyc(); arready = 0;
    for (int b = 0; b < v.nbeats; b++) begin
      if (v.stall > 0) begin
        n = $urandom_range(0, 2);
        repeat (n) begin rvalid = 0; cyc(); end
      end
      rvalid = 1; rdata = v.beats[b]; rlast = (b == v.nbeats - 1);
      #1;
      if (b == 0) chk("rready", 32'(rready), 32'd1);
      cyc();
    end
    rvalid = 0; rlast = 0; rdata = 0;
    #1;
    t = 0;
    while (!awvalid && t < 40) begin cyc(); #1; t++; end
    if (!awvalid) begin chk("awvalid_wait", 32'(awvalid), 32'd1); recover(); return; end
    n = $urandom_range(0, v.stall);
    repeat (n) begin chk("aw_hold", 32'(awvalid), 32'd1); cyc(); #1; end
    chk("awaddr", awaddr, oa);
    chk("awlen", 32'(awlen), 32'(v.awlen));
    awready = 1; cyc(); awready = 0;
    #1;
    for (int j = 0; j < nw; j++) begin
      if (j == abort_at) return;
      ew = exp_q[0]; es = exp_strb_q[0]; m = strb_mask(es);
      n = $urandom_range(0, v.stall);
      repeat (n) begin
        wready = 0; #1;
        chk("w_hold_valid", 32'(wvalid), 32'd1);
        chk("w_hold_data", wdata & m, ew & m);
        cyc();
      end
      wready = 1; #1;
      chk("wvalid", 32'(wvalid), 32'd1);
      chk("wdata", wdata & m, ew & m);
      chk("wstrb", 32'(wstrb), 32'(es));
      chk("wlast", 32'(wlast), 32'(j == nw - 1));
      if (j == 0 && v.chk0) chk("word0", wdata, v.word0);
      void'(exp_q.pop_front());
      void'(exp_strb_q.pop_front());
      cyc(); wready = 0;
    end
    #1;
    n = $urandom_range(0, v.stall);
    repeat (n) begin
      chk("bready", 32'(bready), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      cyc(); #1;
    end
    bvalid = 1; bresp = v.bresp; #1;
    chk("done", 32'(done), 32'd1);
    chk("err", 32'(err), 32'(v.exp_err));
    cyc(); bvalid = 0; bresp = 0; #1;
    chk("busy_end", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
    if (busy) recover();
  endtask

  function automatic vec_t mk(input logic [3:0] sel, input logic [3:0] cnt, input int nb,
                              input logic [7:0] arl, input logic [7:0] awl,
                              input logic [1:0] br, input logic ee, input int st,
                              input logic c0, input logic [31:0] w0);
    vec_t v;
    v.sel = sel; v.cnt = cnt; v.nbeats = nb; v.beats = '0;
    v.arlen = arl; v.awlen = awl; v.bresp = br; v.exp_err = ee;
    v.stall = st; v.chk0 = c0; v.word0 = w0;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    clear_inputs();
    in_addr = 0; out_addr = 0; byte_cnt = 0; data_sel = 0;
    reset = 1;
    repeat (3) cyc();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 0;

    // OP2, 3+1 bytes in one beat
    vecs[0] = mk(4'd2, 4'd3, 1, 8'd0, 8'd1, 2'd0, 1'b0, 0, 1'b1, 32'h2211A523);
    vecs[0].beats[0] = 32'h44332211;
    // OP0, one byte per beat, upper bytes noise
    vecs[1] = mk(4'd0, 4'd3, 4, 8'd3, 8'd1, 2'd0, 1'b0, 0, 1'b1, 32'hBBAAA503);
    vecs[1].beats[0] = {24'($urandom), 8'hAA};
    vecs[1].beats[1] = {24'($urandom), 8'hBB};
    vecs[1].beats[2] = {24'($urandom), 8'hCC};
    vecs[1].beats[3] = {24'($urandom), 8'hDD};
    // OP1, maximum payload: payload byte k == k
    vecs[2] = mk(4'd1, 4'd15, 8, 8'd7, 8'd4, 2'd0, 1'b0, 0, 1'b1, 32'h0100A51F);
    for (int i = 0; i < 8; i++) vecs[2].beats[i] = {16'($urandom), 8'(2*i+1), 8'(2*i)};
    // Same frame as the first, with random stalls on every channel
    vecs[3] = vecs[0];
    vecs[3].stall = 5;
    // Premature rlast after 2 of 4 beats
    vecs[4] = mk(4'd0, 4'd3, 2, 8'd3, 8'd1, 2'd0, 1'b1, 0, 1'b1, 32'hBBAAA503);
    vecs[4].beats[0] = 32'h000000AA;
    vecs[4].beats[1] = 32'h000000BB;
    // Extra beat beyond the single expected one
    vecs[5] = mk(4'd2, 4'd3, 2, 8'd0, 8'd1, 2'd0, 1'b1, 0, 1'b1, 32'h2211A523);
    vecs[5].beats[0] = 32'h44332211;
    vecs[5].beats[1] = 32'h88776655;
    // Minimum payload, single full-strobe word, error write response
    vecs[6] = mk(4'd2, 4'd0, 1, 8'd0, 8'd0, 2'd2, 1'b1, 2, 1'b0, 32'h0);
    vecs[6].beats[0] = $urandom;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], -1);

    // Unsupported merge op: no read traffic, done/err the next cycle
    cyc(); data_sel = 4'd3; byte_cnt = 4'd5; start = 1;
    cyc(); start = 0; #1;
    chk("bad_done", 32'(done), 32'd1);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_arvalid", 32'(arvalid), 32'd0);
    cyc(); #1;
    chk("bad_done_pulse", 32'(done), 32'd0);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_arvalid2", 32'(arvalid), 32'd0);

    // Reset while the write burst is in progress, then a clean packet
    run_vec(vecs[0], 1);
    chk("pre_rst_wvalid", 32'(wvalid), 32'd1);
    wready = 0; reset = 1;
    cyc(); reset = 0; #1;
    chk("abort_arvalid", 32'(arvalid), 32'd0);
    chk("abort_awvalid", 32'(awvalid), 32'd0);
    chk("abort_wvalid", 32'(wvalid), 32'd0);
    chk("abort_rready", 32'(rready), 32'd0);
    chk("abort_bready", 32'(bready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    exp_q.delete(); exp_strb_q.delete();
    run_vec(vecs[0], -1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
